// File: rtl/sram_arbiter_2p.sv
// Two-port arbiter in front of a single-port SRAM macro with 1-cycle read latency.
// Define SRAM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module sram_arbiter_2p #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] sram_a,
    output logic          sram_csb,
    output logic          sram_web,
    output logic          sram_oeb,
    output logic [DW-1:0] sram_i,
    input  logic [DW-1:0] sram_o
);

    logic       gnt0_s;
    logic       gnt1_s;
    logic [1:0] rsp_valid_d;
    logic [1:0] rsp_valid_q;

`ifdef SRAM_ARB_RR_EN
    // last_q = 1 means port 1 was granted most recently
    logic last_d;
    logic last_q;

    // Round-robin grant; rst_n gating forces ready low asynchronously in reset
    always_comb begin
        gnt0_s = rst_n & req0_valid & (~req1_valid | last_q);
        gnt1_s = rst_n & req1_valid & (~req0_valid | ~last_q);
    end

    // Pointer moves only when a transfer happens
    always_comb begin
        last_d = last_q;
        if (gnt0_s) begin
            last_d = 1'b0;
        end else if (gnt1_s) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // Last-granted pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: port 0 always wins contention
    always_comb begin
        gnt0_s = rst_n & req0_valid;
        gnt1_s = rst_n & req1_valid & ~req0_valid;
    end
`endif

    // SRAM command mux from the granted request
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_a   = {AW{1'b0}};
        sram_i   = {DW{1'b0}};
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                sram_csb = 1'b0;
                sram_web = ~req0_we;
                sram_a   = req0_addr;
                sram_i   = req0_wdata;
            end
            2'b10: begin
                sram_csb = 1'b0;
                sram_web = ~req1_we;
                sram_a   = req1_addr;
                sram_i   = req1_wdata;
            end
            default: begin
                sram_csb = 1'b1;
                sram_web = 1'b1;
                sram_a   = {AW{1'b0}};
                sram_i   = {DW{1'b0}};
            end
        endcase
    end

    // Only granted reads produce a response on the following cycle
    always_comb begin
        rsp_valid_d = {gnt1_s & ~req1_we, gnt0_s & ~req0_we};
    end

    // Response-valid flags; reset drops any read still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 2'b00;
        end else begin
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Read data comes straight from the macro during the response cycle
    always_comb begin
        req0_ready = gnt0_s;
        req1_ready = gnt1_s;
        rsp0_valid = rsp_valid_q[0];
        rsp1_valid = rsp_valid_q[1];
        rsp0_rdata = rsp_valid_q[0] ? sram_o : {DW{1'b0}};
        rsp1_rdata = rsp_valid_q[1] ? sram_o : {DW{1'b0}};
        sram_oeb   = ~rst_n;
    end

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Scoreboard bench for sram_arbiter_2p with a behavioural 1-cycle-latency SRAM model.
module tb_sram_arbiter_2p;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic [AW-1:0] sram_a;
    logic          sram_csb, sram_web, sram_oeb;
    logic [DW-1:0] sram_i, sram_o;

    sram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_a(sram_a), .sram_csb(sram_csb), .sram_web(sram_web),
        .sram_oeb(sram_oeb), .sram_i(sram_i), .sram_o(sram_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM macro model: synchronous, output updates only on reads
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        sram_o = 32'h0;
    end
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else           sram_o <= mem[sram_a];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    task automatic push0(input logic [DW-1:0] d);
        exp_t e; e.data = d; e.due = cyc + 1; q0.push_back(e);
    endtask
    task automatic push1(input logic [DW-1:0] d);
        exp_t e; e.data = d; e.due = cyc + 1; q1.push_back(e);
    endtask

    task automatic mon_port(input string nm, input logic v, input logic [DW-1:0] d,
                            input logic has, input exp_t e, output logic pop);
        logic exp_now;
        exp_now = has && (e.due == cyc);
        pop = 1'b0;
        if (v || exp_now) begin
            chk({nm, "_valid"}, {63'd0, v}, {63'd0, exp_now});
            if (v && exp_now) chk({nm, "_rdata"}, {32'd0, d}, {32'd0, e.data});
            pop = exp_now;
        end else begin
            chk({nm, "_rdata_idle"}, {32'd0, d}, 64'd0);
        end
    endtask

    // Monitor: compare responses against the scoreboard on every falling edge
    always @(negedge clk) begin
        exp_t e0, e1;
        logic h0, h1, p0, p1;
        h0 = (q0.size() > 0);
        h1 = (q1.size() > 0);
        e0.data = 32'h0; e0.due = -1;
        e1.data = 32'h0; e1.due = -1;
        if (h0) e0 = q0[0];
        if (h1) e1 = q1[0];
        mon_port("rsp0", rsp0_valid, rsp0_rdata, h0, e0, p0);
        mon_port("rsp1", rsp1_valid, rsp1_rdata, h1, e1, p1);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask
    task automatic set1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b1, 1'b1, 9'h005, 32'hAAAA5555);
        set1(1'b1, 1'b0, 9'h006, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst_csb",    {63'd0, sram_csb},   64'd1);
        chk("rst_web",    {63'd0, sram_web},   64'd1);
        chk("rst_oeb",    {63'd0, sram_oeb},   64'd1);
        chk("rst_a",      {55'd0, sram_a},     64'd0);
        chk("rst_i",      {32'd0, sram_i},     64'd0);

        next_cycle();
        rst_n = 1'b1;
        set0(1'b0, 1'b0, 9'h000, 32'h0);
        set1(1'b0, 1'b0, 9'h000, 32'h0);
        @(negedge clk);
        chk("idle_csb", {63'd0, sram_csb}, 64'd1);
        chk("idle_oeb", {63'd0, sram_oeb}, 64'd0);

        // Write port 0 then read back through port 1
        next_cycle();
        set0(1'b1, 1'b1, 9'h005, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_ready0", {63'd0, req0_ready}, 64'd1);
        chk("wr_ready1", {63'd0, req1_ready}, 64'd0);
        chk("wr_csb",    {63'd0, sram_csb},   64'd0);
        chk("wr_web",    {63'd0, sram_web},   64'd0);
        chk("wr_a",      {55'd0, sram_a},     64'h005);
        chk("wr_i",      {32'd0, sram_i},     64'hDEADBEEF);
        next_cycle();
        set0(1'b0, 1'b0, 9'h000, 32'h0);
        set1(1'b1, 1'b0, 9'h005, 32'h0);
        push1(32'hDEADBEEF);
        @(negedge clk);
        chk("rd_ready1", {63'd0, req1_ready}, 64'd1);
        chk("rd_web",    {63'd0, sram_web},   64'd1);
        chk("rd_a",      {55'd0, sram_a},     64'h005);
        next_cycle();
        set1(1'b0, 1'b0, 9'h000, 32'h0);

        // Preload 0x1FF, then read / write / read with no bubbles
        set0(1'b1, 1'b1, 9'h1FF, 32'h11111111);
        @(negedge clk);
        chk("pre_ready0", {63'd0, req0_ready}, 64'd1);
        next_cycle();
        set0(1'b1, 1'b0, 9'h1FF, 32'h0);
        push0(32'h11111111);
        @(negedge clk);
        chk("b2b_rd1_ready0", {63'd0, req0_ready}, 64'd1);
        next_cycle();
        set0(1'b1, 1'b1, 9'h1FF, 32'h22222222);
        @(negedge clk);
        chk("b2b_wr_ready0", {63'd0, req0_ready}, 64'd1);
        chk("b2b_wr_web",    {63'd0, sram_web},   64'd0);
        next_cycle();
        set0(1'b1, 1'b0, 9'h1FF, 32'h0);
        push0(32'h22222222);
        @(negedge clk);
        chk("b2b_rd2_ready0", {63'd0, req0_ready}, 64'd1);
        next_cycle();
        set0(1'b0, 1'b0, 9'h000, 32'h0);
        next_cycle();

        // Contention from a fresh reset
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 9'h005, 32'h0);
        set1(1'b1, 1'b0, 9'h1FF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic w0;
`ifdef SRAM_ARB_RR_EN
            w0 = (k % 2 == 0);
`else
            w0 = 1'b1;
`endif
            @(negedge clk);
            chk($sformatf("cont%0d_ready0", k), {63'd0, req0_ready}, {63'd0, w0});
            chk($sformatf("cont%0d_ready1", k), {63'd0, req1_ready}, {63'd0, ~w0});
            if (w0) push0(32'hDEADBEEF);
            else    push1(32'h22222222);
            next_cycle();
        end
        set0(1'b0, 1'b0, 9'h000, 32'h0);
        @(negedge clk);
        chk("cont_after_ready1", {63'd0, req1_ready}, 64'd1);
        push1(32'h22222222);
        next_cycle();
        set1(1'b0, 1'b0, 9'h000, 32'h0);
        next_cycle();

        // Reset arriving while a read response is due
        set0(1'b1, 1'b0, 9'h005, 32'h0);
        @(negedge clk);
        chk("rr_ready0", {63'd0, req0_ready}, 64'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("rr_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        chk("rr_csb",        {63'd0, sram_csb},   64'd1);
        chk("rr_oeb",        {63'd0, sram_oeb},   64'd1);
        chk("rr_ready0",     {63'd0, req0_ready}, 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        set0(1'b0, 1'b0, 9'h000, 32'h0);
        repeat (3) next_cycle();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_2p.md
SRAM_ARBITER_2P -- requirements
Module: sram_arbiter_2p

Interface
REQ-001 The block SHALL expose parameter AW, default 9, the SRAM word-address width.
REQ-002 The block SHALL expose parameter DW, default 32, the SRAM data width.
REQ-003 Port list SHALL start with the clock and reset.
- clk  input  1  the single clock; also drives the SRAM macro clock (CE).
- rst_n  input  1  asynchronous active-low reset.
REQ-004 Each requester N (N = 0, 1) SHALL have these ports:
- reqN_valid  input  1  request present.
- reqN_ready  output  1  request accepted this cycle.
- reqN_we  input  1  1 = write, 0 = read.
- reqN_addr  input  AW  word address.
- reqN_wdata  input  DW  write data.
- rspN_valid  output  1  read data valid.
- rspN_rdata  output  DW  read data.
REQ-005 The SRAM-side ports SHALL be:
- sram_a  output  AW  address.
- sram_csb  output  1  chip select, active low.
- sram_web  output  1  write enable, active low.
- sram_oeb  output  1  output enable, active low.
- sram_i  output  DW  write data.
- sram_o  input  DW  macro read data.

Function
REQ-006 The block SHALL grant at most one request per cycle; a request transfers on a cycle where reqN_valid and reqN_ready are both 1.
REQ-007 reqN_ready SHALL be combinational from the valid inputs and the arbitration state, and SHALL be 1 only for the granted port.
REQ-008 With a single valid requester, that requester SHALL be granted in the same cycle.
REQ-009 SRAM controls SHALL be combinational from the granted request:
- sram_csb = 0 only when a grant exists.
- sram_web = ~we of the granted request.
- sram_a and sram_i come from the granted request.
- With no grant: sram_csb = 1, sram_web = 1, sram_a and sram_i = 0.
REQ-010 sram_oeb SHALL be 0 at all times outside reset.
REQ-011 For a granted read at edge T, rspN_valid SHALL be 1 during cycle T+1 only, and rspN_rdata SHALL equal sram_o in that cycle. Read latency is exactly 1 cycle.
REQ-012 rspN_rdata SHALL be 0 whenever rspN_valid is 0.
REQ-013 A granted write SHALL produce no response.
REQ-014 Back-to-back transfers SHALL be sustained at one per cycle with no bubble, including a read followed immediately by a write to the same address (the read returns the old data).
REQ-015 The arbitration state (last-granted pointer) SHALL update only on a transfer.
REQ-016 A requester holding reqN_valid SHALL keep its fields stable until reqN_ready is 1. The block does not check this rule.

Reset
REQ-017 While rst_n = 0, the outputs SHALL be forced asynchronously to: reqN_ready = 0, rspN_valid = 0, rspN_rdata = 0, sram_csb = 1, sram_web = 1, sram_oeb = 1, sram_a = 0, sram_i = 0.
REQ-018 Reset SHALL set the last-granted pointer to port 1, so port 0 wins the first contention.
REQ-019 A read granted in the cycle before reset asserts SHALL return no response; memory contents are not affected by reset.

Configuration
REQ-020 With macro SRAM_ARB_RR_EN defined, contention SHALL be resolved round-robin: the port not granted last wins.
REQ-021 Without SRAM_ARB_RR_EN, contention SHALL be resolved by fixed priority: port 0 always wins, and the pointer logic is absent.

Verification
REQ-022 Write port0 addr 0x005 data 0xDEADBEEF, then read port1 addr 0x005 -> rsp1_valid one cycle after the read grant with rdata 0xDEADBEEF, and rsp0_valid stays 0.
REQ-023 With SRAM_ARB_RR_EN, both ports request reads continuously from reset -> grant sequence 0,1,0,1; each rspN_valid appears the cycle after that port's own grant.
REQ-024 Without SRAM_ARB_RR_EN, both ports request continuously for 4 cycles -> req1_ready stays 0 throughout; port 1 is granted in the first cycle after port 0 drops valid.
REQ-025 Read addr 0x1FF (old data 0x11111111), then write 0x22222222 to 0x1FF the next cycle, then read again -> responses 0x11111111 then 0x22222222, with no idle cycles between the three transfers.
REQ-026 Assert rst_n = 0 the cycle after a port0 read grant -> rsp0_valid = 0, sram_csb = 1, and sram_oeb = 1 immediately, with no response after reset releases.
